// File: rtl/zigzag_buf.sv
// Ping-pong reorder buffer: natural-order 8x8 blocks in (one row per beat),
// JPEG zigzag-order blocks out (eight coefficients per beat).
module zigzag_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic        out_sof,
    output logic        out_eob,
    input  logic        out_ready,
    output logic [3:0]  bank_state
);

    // Handshake: a beat transfers on a rising edge where valid & ready are both
    // high; valid never depends on ready, and a stalled output holds its payload.

    localparam logic [1:0] BANK_EMPTY   = 2'd0;
    localparam logic [1:0] BANK_FILLING = 2'd1;
    localparam logic [1:0] BANK_FULL    = 2'd2;

    // Zigzag index i -> natural address, entry i at bits [(63-i)*6 +: 6].
    localparam logic [383:0] ZZ_TABLE = {
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [7:0]  mem [0:127];
    logic [1:0]  full;
    logic [1:0]  full_next;
    logic        wr_sel;
    logic        rd_sel;
    logic [2:0]  wr_row;
    logic [2:0]  rd_beat;
    logic        wr_fire;
    logic        rd_load;
    logic [63:0] zz_data;
    logic [5:0]  zz_addr;
    int          zz_pos;

    assign in_ready = ~full[wr_sel];
    assign wr_fire  = in_valid & in_ready;
    assign rd_load  = full[rd_sel] & (~out_valid | out_ready);

    always_comb begin
        zz_data = '0;
        zz_addr = '0;
        zz_pos  = 0;
        for (int j = 0; j < 8; j++) begin
            zz_pos  = (63 - (int'(rd_beat) * 8 + j)) * 6;
            zz_addr = ZZ_TABLE[zz_pos +: 6];
            zz_data[63 - 8 * j -: 8] = mem[{rd_sel, zz_addr}];
        end
    end

    always_comb begin
        full_next = full;
        if (wr_fire && wr_row == 3'd7)
            full_next[wr_sel] = 1'b1;
        if (rd_load && rd_beat == 3'd7)
            full_next[rd_sel] = 1'b0;
    end

    // Bank storage is never reset; its contents only matter once marked full.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int c = 0; c < 8; c++)
                mem[{wr_sel, wr_row, 3'(c)}] <= in_data[63 - 8 * c -: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full      <= 2'b00;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_row    <= 3'd0;
            rd_beat   <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= 64'd0;
            out_sof   <= 1'b0;
            out_eob   <= 1'b0;
        end else begin
            full <= full_next;
            if (wr_fire) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7)
                    wr_sel <= ~wr_sel;
            end
            if (rd_load) begin
                out_valid <= 1'b1;
                out_data  <= zz_data;
                out_sof   <= (rd_beat == 3'd0);
                out_eob   <= (rd_beat == 3'd7);
                rd_beat   <= rd_beat + 3'd1;
                if (rd_beat == 3'd7)
                    rd_sel <= ~rd_sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        bank_state = '0;
        for (int b = 0; b < 2; b++) begin
            if (full[b])
                bank_state[2 * b +: 2] = BANK_FULL;
            else if (wr_sel == 1'(b) && wr_row != 3'd0)
                bank_state[2 * b +: 2] = BANK_FILLING;
            else
                bank_state[2 * b +: 2] = BANK_EMPTY;
        end
    end

endmodule

// File: tb/tb_zigzag_buf.sv
// Scoreboarded bench for zigzag_buf: drivers push expected zigzag beats when a
// block's last row is accepted; a monitor pops them as output beats transfer.
module tb_zigzag_buf;

    localparam int ZZ [64] = '{
        0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = 64'd0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_sof;
    logic        out_eob;
    logic        out_ready = 1'b0;
    logic [3:0]  bank_state;

    int          tests = 0;
    int          fails = 0;
    int          rows_accepted = 0;
    int          ready_mode = 1;
    logic [65:0] exp_q [$];
    logic [7:0]  cur_blk [64];

    bit          track = 1'b0;
    int          run = 0;
    int          max_run = 0;
    int          drops = 0;
    bit          sender_done = 1'b0;

    zigzag_buf dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_eob    (out_eob),
        .out_ready  (out_ready),
        .bank_state (bank_state)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached with %0d beats outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [65:0] zz_beat(input int k);
        logic [63:0] d;
        d = '0;
        for (int j = 0; j < 8; j++)
            d[63 - 8 * j -: 8] = cur_blk[ZZ[8 * k + j]];
        return {k == 0, k == 7, d};
    endfunction

    function automatic logic [63:0] row_word(input int r);
        logic [63:0] w;
        w = '0;
        for (int c = 0; c < 8; c++)
            w[63 - 8 * c -: 8] = cur_blk[8 * r + c];
        return w;
    endfunction

    // mode 0: ramp (8r+c) xor key; mode 1: random bytes
    task automatic fill_block(input int mode, input logic [7:0] key);
        for (int i = 0; i < 64; i++)
            cur_blk[i] = (mode == 0) ? (8'(i) ^ key) : 8'($urandom_range(0, 255));
    endtask

    // ---------------- drivers ----------------
    task automatic send_row(input logic [63:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 2000) begin
                check("send_row_timeout", 66'(in_ready), 66'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rows_accepted++;
    endtask

    task automatic send_rows(input int first, input int last, input bit gaps);
        for (int r = first; r <= last; r++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_row(row_word(r));
        end
    endtask

    task automatic push_block();
        for (int k = 0; k < 8; k++)
            exp_q.push_back(zz_beat(k));
    endtask

    task automatic send_block(input int mode, input logic [7:0] key, input bit gaps);
        fill_block(mode, key);
        send_rows(0, 7, gaps);
        push_block();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_remaining", 66'(exp_q.size()), 66'd0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {out_sof, out_eob, out_data}, 66'd0 - 66'd1);
            end else begin
                check("beat", {out_sof, out_eob, out_data}, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (track) begin
            if (out_valid) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (in_valid && !in_ready) drops++;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int seen;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 66'(out_valid), 66'd0);
        check("reset_out_data", 66'(out_data), 66'd0);
        check("reset_sof_eob", 66'({out_sof, out_eob}), 66'd0);
        check("reset_in_ready", 66'(in_ready), 66'd1);
        check("reset_bank_state", 66'(bank_state), 66'd0);
        @(posedge clk);
        #1;

        // Ramp block: latency and the two boundary beats.
        ready_mode = 1;
        @(posedge clk);
        #1;
        send_block(0, 8'h00, 1'b0);
        check("latency_not_yet", 66'(out_valid), 66'd0);
        @(posedge clk);
        #1;
        check("ramp_beat0", {out_valid, out_sof, out_eob, out_data}, {3'b110, 64'h00010810_0902030A});
        repeat (7) @(posedge clk);
        #1;
        check("ramp_beat7", {out_valid, out_sof, out_eob, out_data}, {3'b101, 64'h353C3D36_2F373E3F});
        wait_drain();

        // Four back-to-back blocks: no bubbles on either side.
        run = 0;
        max_run = 0;
        drops = 0;
        track = 1'b1;
        for (int b = 0; b < 4; b++)
            send_block(0, 8'(b), 1'b0);
        wait_drain();
        track = 1'b0;
        check("b2b_valid_run", 66'(max_run), 66'd32);
        check("b2b_in_ready_drops", 66'(drops), 66'd0);

        // Output stalled for 30 cycles while input streams.
        ready_mode = 0;
        @(posedge clk);
        #1;
        base = rows_accepted;
        sender_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 3; b++)
                    send_block(0, 8'h40 + 8'(b), 1'b0);
                sender_done = 1'b1;
            end
        join_none
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("stall_rows_accepted", 66'(rows_accepted - base), 66'd16);
        check("stall_in_ready", 66'(in_ready), 66'd0);
        check("stall_bank_state", 66'(bank_state), 66'h0A);
        check("stall_hold_beat0", {out_valid, out_sof, out_eob, out_data}, {3'b110, 64'h40414850_4942434A});
        ready_mode = 1;
        seen = 0;
        while (!sender_done && seen < 500) begin
            @(posedge clk);
            seen++;
        end
        check("stall_sender_done", 66'(sender_done), 66'd1);
        wait_drain();

        // Random gaps on both sides.
        ready_mode = 2;
        for (int b = 0; b < 100; b++)
            send_block(1, 8'h00, 1'b1);
        ready_mode = 1;
        wait_drain();

        // Reset while block 0 drains and block 1 is partly written.
        send_block(0, 8'h00, 1'b0);
        fill_block(0, 8'h11);
        send_rows(0, 4, 1'b0);
        exp_q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", 66'(out_valid), 66'd0);
        check("midreset_in_ready", 66'(in_ready), 66'd1);
        @(posedge clk);
        #1;
        send_block(0, 8'h00, 1'b0);
        wait_drain();

        // Partial block waits indefinitely.
        fill_block(0, 8'h22);
        send_rows(0, 0, 1'b0);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("partial_no_output", 66'(seen), 66'd0);
        check("partial_bank_state", 66'(bank_state), 66'h4);
        @(posedge clk);
        #1;
        send_rows(1, 7, 1'b0);
        push_block();
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
